stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop and lap/clear button handling with a
// tick-timed lap-display hold. All outputs are registered (1-cycle latency).
module stopwatch_ctrl #(
   parameter int unsigned HOLD_TICKS = 300,
   parameter int unsigned CW         = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic       run,
   output logic       clr,
   output logic       lap_load,
   output logic       sel,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      LAP   = 2'b10,
      PAUSE = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic            run_q, run_d;
   logic            sel_q, sel_d;
   logic            clr_q, clr_d;
   logic            lap_load_q, lap_load_d;
   logic            ss_q, lap_q;
   logic            ss_rise, lap_rise, lap_acc;

   assign ss_rise  = btn_ss & ~ss_q;
   assign lap_rise = btn_lap & ~lap_q;
   // A lap edge only counts when it is not shadowed by a start/stop edge.
   assign lap_acc  = lap_rise & ~ss_rise;

   // Edge registers reset high so a button held through reset is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         run_q      <= 1'b0;
         sel_q      <= 1'b0;
         clr_q      <= 1'b0;
         lap_load_q <= 1'b0;
         ss_q       <= 1'b1;
         lap_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         run_q      <= run_d;
         sel_q      <= sel_d;
         clr_q      <= clr_d;
         lap_load_q <= lap_load_d;
         ss_q       <= btn_ss;
         lap_q      <= btn_lap;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (ss_rise) state_d = RUN;
         end
         RUN: begin
            if (ss_rise) begin
               state_d = PAUSE;
            end else if (lap_rise) begin
               state_d = LAP;
               hold_d  = CW'(HOLD_TICKS);
            end
         end
         LAP: begin
            if (ss_rise) begin
               state_d = PAUSE;
            end else if (lap_rise) begin
               hold_d  = CW'(HOLD_TICKS);
            end else if (tick) begin
               if (hold_q <= CW'(1)) begin
                  state_d = RUN;
                  hold_d  = '0;
               end else begin
                  hold_d  = hold_q - CW'(1);
               end
            end
         end
         PAUSE: begin
            if (ss_rise)       state_d = RUN;
            else if (lap_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != LAP) hold_d = '0;
   end

   always_comb begin
      run_d      = (state_d == RUN) || (state_d == LAP);
      sel_d      = (state_d == LAP);
      clr_d      = lap_acc & ((state_q == IDLE) || (state_q == PAUSE));
      lap_load_d = lap_acc & ((state_q == RUN) || (state_q == LAP));
   end

   assign run      = run_q;
   assign sel      = sel_q;
   assign clr      = clr_q;
   assign lap_load = lap_load_q;
   assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: each driven cycle pushes the expected
// {state,run,sel,clr,lap_load}; it is popped and compared one edge later.
module tb_stopwatch_ctrl;

   localparam int unsigned HT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       btn_ss = 1'b0;
   logic       btn_lap = 1'b0;
   logic       run, clr, lap_load, sel;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [5:0] exp_q[$];
   string      tag_q[$];

   // Expected vectors: {state, run, sel, clr, lap_load}
   localparam logic [5:0] E_IDLE  = 6'b00_0_0_0_0;
   localparam logic [5:0] E_CLR   = 6'b00_0_0_1_0;
   localparam logic [5:0] E_RUN   = 6'b01_1_0_0_0;
   localparam logic [5:0] E_LAP   = 6'b10_1_1_0_0;
   localparam logic [5:0] E_LAPLD = 6'b10_1_1_0_1;
   localparam logic [5:0] E_PAUSE = 6'b11_0_0_0_0;

   stopwatch_ctrl #(.HOLD_TICKS(HT), .CW(9)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .btn_ss   (btn_ss),
      .btn_lap  (btn_lap),
      .run      (run),
      .clr      (clr),
      .lap_load (lap_load),
      .sel      (sel),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("ok   %-14s obs=%b exp=%b", tag, obs, exp);
      end else begin
         $display("FAIL %-14s obs=%b exp=%b (state,run,sel,clr,lap_load)", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive one cycle of stimulus, score the result after the next posedge.
   task automatic step(input logic ss, input logic lp, input logic tk,
                       input logic [5:0] exp, input string tag);
      logic [5:0] e;
      string      t;
      btn_ss  = ss;
      btn_lap = lp;
      tick    = tk;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {state, run, sel, clr, lap_load}, e);
      @(negedge clk);
   endtask

   initial begin
      #1;
      check_eq("reset_state", {state, run, sel, clr, lap_load}, E_IDLE);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      step(0, 0, 0, E_IDLE,  "idle_quiet");
      step(1, 0, 0, E_RUN,   "start");
      step(0, 0, 1, E_RUN,   "run_tick");
      step(1, 0, 0, E_PAUSE, "stop");
      step(1, 0, 0, E_PAUSE, "ss_held");
      step(0, 0, 0, E_PAUSE, "pause_quiet");
      step(0, 1, 0, E_CLR,   "pause_clr");
      step(0, 1, 0, E_IDLE,  "clr_once");
      step(0, 0, 0, E_IDLE,  "idle_rel");
      step(0, 1, 0, E_CLR,   "idle_clr");
      step(0, 0, 0, E_IDLE,  "idle_rel2");
      step(1, 0, 0, E_RUN,   "start2");
      step(0, 0, 0, E_RUN,   "run_quiet");
      step(0, 1, 0, E_LAPLD, "lap_enter");
      step(0, 1, 0, E_LAP,   "lap_held");
      step(0, 0, 1, E_LAP,   "hold_tick1");
      step(0, 0, 0, E_LAP,   "hold_notick");
      step(0, 0, 1, E_LAP,   "hold_tick2");
      step(0, 0, 1, E_RUN,   "lap_expire");
      step(0, 1, 0, E_LAPLD, "lap_again");
      step(0, 0, 1, E_LAP,   "hold2_tick1");
      step(0, 0, 1, E_LAP,   "hold2_tick2");
      step(0, 1, 1, E_LAPLD, "lap_vs_expire");
      step(0, 0, 1, E_LAP,   "reload_tick1");
      step(0, 0, 1, E_LAP,   "reload_tick2");
      step(0, 0, 1, E_RUN,   "reload_expire");
      step(0, 0, 0, E_RUN,   "run_quiet2");
      step(1, 1, 0, E_PAUSE, "both_run");
      step(0, 0, 0, E_PAUSE, "pause_quiet2");
      step(1, 0, 0, E_RUN,   "resume");
      step(0, 1, 0, E_LAPLD, "lap_enter2");
      step(1, 0, 0, E_PAUSE, "lap_stop");
      step(0, 0, 1, E_PAUSE, "pause_tick");
      step(1, 0, 0, E_RUN,   "resume2");
      step(0, 1, 0, E_LAPLD, "lap_enter3");
      step(0, 0, 0, E_LAP,   "lap_quiet");
      step(1, 1, 0, E_PAUSE, "both_lap");
      step(0, 0, 0, E_PAUSE, "pause_quiet3");
      step(1, 0, 0, E_RUN,   "resume3");
      step(0, 1, 0, E_LAPLD, "lap_enter4");

      // lap_load is still high here; reset must clear it without a clock edge.
      reset  = 1'b1;
      btn_ss = 1'b1;
      #1;
      check_eq("async_reset", {state, run, sel, clr, lap_load}, E_IDLE);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      step(1, 0, 0, E_IDLE, "ss_held_rst");
      step(1, 0, 0, E_IDLE, "ss_held_rst2");
      step(0, 0, 0, E_IDLE, "ss_released");
      step(1, 0, 0, E_RUN,  "ss_repress");

      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain obs=%0d pending exp=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
